// File: rtl/remote_comm_pkg.sv
// Shared types and response codes for the host command sender and the robot side.
package remote_comm_pkg;

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} rc_state_t;

  localparam logic [7:0] ACK     = 8'hA5;
  localparam logic [7:0] POS_ACK = 8'h5A;

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART transceiver: tx_done is a level cleared by trmt; rx_rdy is a level
// cleared by clr_rx_rdy or by the next start bit.
module remote_comm_uart #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);
  localparam int unsigned BW = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  // First sample lands mid start bit; the two-flop synchroniser delay is taken out.
  localparam logic [BW-1:0] BAUD_HALF = BW'((BAUD_DIV >= 4) ? (BAUD_DIV / 2 - 2) : 0);

  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_busy_q, tx_busy_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_done_q, tx_done_d;

  logic          rx_sync1_q, rx_sync2_q;
  logic          rx_busy_q, rx_busy_d;
  logic [BW-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [8:0]    rx_shift_q, rx_shift_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic [7:0]    rx_data_q, rx_data_d;

  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_busy_d  = tx_busy_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_done_d  = tx_done_q;
    if (trmt) begin
      tx_shift_d = {1'b1, tx_data, 1'b0};
      tx_busy_d  = 1'b1;
      tx_baud_d  = '0;
      tx_bit_d   = '0;
      tx_done_d  = 1'b0;
    end else if (tx_busy_q) begin
      if (tx_baud_q == BAUD_LAST) begin
        tx_baud_d  = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_done_d = 1'b1;
        end
      end else begin
        tx_baud_d = tx_baud_q + 1'b1;
      end
    end
  end

  always_comb begin
    rx_busy_d  = rx_busy_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_rdy_d   = clr_rx_rdy ? 1'b0 : rx_rdy_q;
    if (!rx_busy_q) begin
      if (!rx_sync2_q) begin
        rx_busy_d = 1'b1;
        rx_baud_d = BAUD_HALF;
        rx_bit_d  = '0;
        rx_rdy_d  = 1'b0;
      end
    end else if (rx_baud_q == '0) begin
      rx_baud_d  = BAUD_LAST;
      rx_shift_d = {rx_sync2_q, rx_shift_q[8:1]};
      rx_bit_d   = rx_bit_q + 4'd1;
      if (rx_bit_q == 4'd0 && rx_sync2_q) begin
        rx_busy_d = 1'b0;
      end else if (rx_bit_q == 4'd9) begin
        rx_busy_d = 1'b0;
        rx_rdy_d  = 1'b1;
        rx_data_d = rx_shift_q[8:1];
      end
    end else begin
      rx_baud_d = rx_baud_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '1;
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_done_q  <= 1'b0;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_rdy_q   <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_busy_q  <= tx_busy_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_done_q  <= tx_done_d;
      rx_sync1_q <= RX;
      rx_sync2_q <= rx_sync1_q;
      rx_busy_q  <= rx_busy_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign TX      = tx_shift_q[0];
  assign tx_done = tx_done_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;

endmodule

// File: rtl/remote_comm.sv
// Host command sender: sends a 16-bit command as two UART bytes (high first),
// then waits for the robot's one-byte response or a response timeout.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 1_000_000,
  parameter int unsigned BAUD_DIV     = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        timeout
);
  localparam int unsigned CW = (RESP_TIMEOUT == 0) ? 1 : $clog2(RESP_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RESP_TIMEOUT - 1);

  rc_state_t     state_q, state_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [7:0]    resp_q, resp_d;
  logic          resp_rdy_q, resp_rdy_d;
  logic          cmd_snt_q, cmd_snt_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       trmt, tx_done, rx_rdy, clr_rx_rdy;
  logic [7:0] tx_data, rx_data;

  remote_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy),
    .rx_data    (rx_data),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    resp_d     = resp_q;
    resp_rdy_d = clr_resp_rdy ? 1'b0 : resp_rdy_q;
    cmd_snt_d  = 1'b0;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    trmt       = 1'b0;
    clr_rx_rdy = 1'b0;
    // High byte comes straight from cmd so the start bit is not delayed by cmd_q.
    tx_data    = (state_q == IDLE) ? cmd[15:8] : cmd_q[7:0];
    unique case (state_q)
      IDLE: begin
        clr_rx_rdy = rx_rdy;
        if (snd_cmd) begin
          cmd_d      = cmd;
          trmt       = 1'b1;
          resp_rdy_d = 1'b0;
          state_d    = TX_HI;
        end
      end
      TX_HI: begin
        if (tx_done) begin
          trmt    = 1'b1;
          state_d = TX_LO;
        end
      end
      TX_LO: begin
        if (tx_done) begin
          cmd_snt_d = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (rx_rdy) begin
          resp_d     = rx_data;
          resp_rdy_d = 1'b1;
          clr_rx_rdy = 1'b1;
          state_d    = IDLE;
        end else if (RESP_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
      cmd_snt_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
      cmd_snt_q  <= cmd_snt_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign cmd_snt  = cmd_snt_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: decodes TX frames, plays the robot's response on RX,
// and compares against expected bytes/latencies derived from the command rules.
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int unsigned BAUD = 8;
  localparam int unsigned RT   = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = '0;
  logic        clr_resp_rdy = 1'b0;
  logic        RX = 1'b1;
  logic        TX, busy, cmd_snt, resp_rdy, timeout;
  logic [7:0]  resp;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned busy_low = 0;
  int unsigned snt_cnt = 0;
  int unsigned to_cnt = 0;
  int unsigned frame_err = 0;
  logic [7:0]  tx_bytes[$];
  logic [7:0]  exp_resp = '0;
  logic        exp_rdy = 1'b0;

  remote_comm #(.RESP_TIMEOUT(RT), .BAUD_DIV(BAUD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .snd_cmd      (snd_cmd),
    .cmd          (cmd),
    .clr_resp_rdy (clr_resp_rdy),
    .RX           (RX),
    .TX           (TX),
    .busy         (busy),
    .cmd_snt      (cmd_snt),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (cmd_snt === 1'b1) snt_cnt++;
      if (timeout === 1'b1) to_cnt++;
    end
  end

  // TX line decoder: 8N1, LSB first, sampled mid-bit.
  initial begin
    logic [7:0] b;
    bit ok;
    forever begin
      @(negedge clk);
      if (TX === 1'b0 && rst_n === 1'b1) begin
        repeat (BAUD / 2) @(negedge clk);
        ok = (TX === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        ok = ok && (TX === 1'b1);
        if (ok) tx_bytes.push_back(b);
        else frame_err++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic wait_snt(input int unsigned budget, input int unsigned inject_at,
                          output int unsigned n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) busy_low++;
      if (inject_at != 0 && n == inject_at) begin
        snd_cmd = 1'b1;
        cmd = 16'hFFFF;
      end else begin
        snd_cmd = 1'b0;
      end
      if (cmd_snt === 1'b1) seen = 1'b1;
    end
    snd_cmd = 1'b0;
  endtask

  // One command transaction; respond=0 leaves RX silent to exercise the timeout.
  task automatic do_cmd(input string name, input logic [15:0] c, input int unsigned inject_at,
                        input bit respond, input logic [7:0] rb);
    int unsigned n, k, s0, t0;
    bit seen;
    logic [7:0] exp_q[$];
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    tx_bytes.delete();
    s0 = snt_cnt;
    t0 = to_cnt;
    @(negedge clk);
    snd_cmd = 1'b1;
    cmd = c;
    @(negedge clk);
    snd_cmd = 1'b0;
    cmd = 16'($urandom);
    exp_rdy = 1'b0;
    check({name, "_busy_on_accept"}, busy, 1);
    check({name, "_resp_rdy_cleared"}, resp_rdy, 0);
    busy_low = 0;
    wait_snt(30 * BAUD, inject_at, n, seen);
    check({name, "_cmd_snt_seen"}, seen, 1);
    check({name, "_cmd_snt_latency"}, (n >= 20 * BAUD && n <= 20 * BAUD + 4), 1);
    check({name, "_busy_during_tx"}, busy_low, 0);
    @(negedge clk);
    check({name, "_cmd_snt_width"}, cmd_snt, 0);
    check({name, "_tx_byte_count"}, tx_bytes.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < tx_bytes.size()) check($sformatf("%s_tx_byte%0d", name, i), tx_bytes[i], exp_q[i]);
    end
    if (respond) begin
      repeat ($urandom_range(3)) @(negedge clk);
      rx_send(rb);
      k = 0;
      while (resp_rdy !== 1'b1 && k < 4 * BAUD) begin
        @(negedge clk);
        k++;
      end
      exp_resp = rb;
      exp_rdy = 1'b1;
      check({name, "_resp_rdy"}, resp_rdy, exp_rdy);
      check({name, "_resp"}, resp, exp_resp);
      check({name, "_idle_after_resp"}, busy, 0);
      check({name, "_no_timeout"}, to_cnt - t0, 0);
    end else begin
      k = 1;
      while (timeout !== 1'b1 && k < 2 * RT) begin
        @(negedge clk);
        k++;
      end
      check({name, "_timeout_latency"}, k, RT);
      @(negedge clk);
      check({name, "_timeout_width"}, timeout, 0);
      check({name, "_idle_after_timeout"}, busy, 0);
      check({name, "_resp_rdy_low"}, resp_rdy, 0);
      check({name, "_resp_held"}, resp, exp_resp);
      check({name, "_timeout_pulses"}, to_cnt - t0, 1);
    end
    check({name, "_cmd_snt_pulses"}, snt_cnt - s0, 1);
  endtask

  initial begin
    logic [15:0] rc;
    logic [7:0]  rbyte;

    repeat (3) @(negedge clk);
    check("rst_TX", TX, 1);
    check("rst_busy", busy, 0);
    check("rst_cmd_snt", cmd_snt, 0);
    check("rst_resp", resp, 8'h00);
    check("rst_resp_rdy", resp_rdy, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_cmd("c1", 16'h2A5C, 0, 1'b1, ACK);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    exp_rdy = 1'b0;
    check("clr_resp_rdy", resp_rdy, 0);
    check("clr_resp_held", resp, ACK);

    do_cmd("c3", 16'h1234, 5 * BAUD, 1'b1, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      rc = 16'($urandom);
      rbyte = 8'($urandom);
      do_cmd($sformatf("rnd%0d", i), rc, $urandom_range(19 * BAUD, 1), 1'b1, rbyte);
    end

    repeat (5) @(negedge clk);
    rx_send(8'h77);
    repeat (2 * BAUD) @(negedge clk);
    check("stray_resp", resp, exp_resp);
    check("stray_resp_rdy", resp_rdy, exp_rdy);
    check("stray_busy", busy, 0);
    do_cmd("c5", 16'h8001, 0, 1'b1, POS_ACK);

    do_cmd("c4", 16'h4D2B, 0, 1'b0, 8'h00);

    tx_bytes.delete();
    @(negedge clk);
    snd_cmd = 1'b1;
    cmd = 16'hC3C3;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_TX", TX, 1);
    check("midrst_busy", busy, 0);
    check("midrst_resp_rdy", resp_rdy, 0);
    check("midrst_resp", resp, 8'h00);
    exp_resp = '0;
    exp_rdy = 1'b0;
    repeat (12 * BAUD) @(negedge clk);
    rst_n = 1'b1;
    tx_bytes.delete();
    repeat (2) @(negedge clk);
    do_cmd("c6", 16'h0F0F, 0, 1'b1, ACK);

    check("frame_errors", frame_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
